ahbl_addr_decode_resp_mux: RTL
==============================

Name: ahbl_addr_decode_resp_mux

Overview:
- Address-decode and response-multiplex stage for a single-master AHB-Lite bus.
- Decodes HADDR into one-hot slave selects.
- Raises the request strobe for the default-slave error state machine on unmapped transfers.
- Registers the data-phase owner and routes that owner's HREADYOUT/HRESP/HRDATA back to the master. Feeds the default slave and consumes its outputs.

Parameters:
- SLOT_EN, 16'h00FF: bit i set means 256 MB slot i (HADDR[31:28]==i) is mapped to slave port i; cleared bits are unmapped.
- CNT_W, 16: width of the unmapped-access counter (range 4..32).

Ports:
- HCLK  in  1  bus clock; all state on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HADDR  in  32  master address-phase address.
- HTRANS  in  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HSEL_S  out  16  one-hot address-phase slave selects.
- HREADYOUT_S  in  16  per-slave ready.
- HRESP_S  in  16  per-slave response (1 = ERROR).
- HRDATA_S  in  512  per-slave read data; slave i on bits [32i+31:32i].
- DEF_REQ  out  1  default-slave request (its valid-transfer input).
- DEF_HREADYOUT  in  1  default-slave ready.
- DEF_HRESP  in  1  default-slave response.
- HREADY  out  1  ready to master, also broadcast to all slaves.
- HRESP  out  1  response to master.
- HRDATA  out  32  read data to master.
- UNMAP_CNT  out  CNT_W  saturating count of unmapped transfers accepted.

Behaviour:
- Address-phase decode, combinational: slot = HADDR[31:28].
  - HSEL_S[slot] = SLOT_EN[slot]; all other bits 0. HTRANS is not gated, so IDLE to a mapped slot still selects it.
  - Unmapped = !SLOT_EN[slot].
  - DEF_REQ = unmapped & HTRANS[1] & HREADY.
- Data-phase owner register, 3 kinds: NONE, SLV(i), DEF.
  - Updates only on a clock edge with HREADY=1.
  - Next owner = SLV(slot) if mapped and HTRANS[1]; DEF if unmapped and HTRANS[1]; NONE if HTRANS is IDLE or BUSY.
  - HREADY=0 holds the owner; address-phase inputs are ignored for ownership.
- Response mux, combinational from the owner:
  - SLV(i): HREADY=HREADYOUT_S[i], HRESP=HRESP_S[i], HRDATA=HRDATA_S slice i.
  - DEF: HREADY=DEF_HREADYOUT, HRESP=DEF_HRESP, HRDATA=0.
  - NONE: HREADY=1, HRESP=0, HRDATA=0.
- Reset, HRESET high at a rising edge:
  - Owner=NONE, so HREADY=1, HRESP=0, HRDATA=0.
  - UNMAP_CNT=0.
  - Reset mid-transfer drops the owner immediately, even while a slave is stretching HREADY low.
- UNMAP_CNT:
  - Increments by 1 on each edge where DEF_REQ=1 (i.e., HREADY=1).
  - Saturates at all-ones; no wrap.
  - Cleared only by reset.
- Latency: owner change is visible one cycle after the accepting edge; the mux adds no register stage.
- Back-to-back transfers: address phase of transfer N+1 overlaps the data phase of N. The owner for N+1 is captured on the same edge that completes N (HREADY=1).
- Two-cycle ERROR: the default slave drives HREADY=0/HRESP=1, then HREADY=1/HRESP=1. The owner stays DEF across the first cycle and re-evaluates on the second.
  - Unmapped NONSEQ presented during that second cycle → DEF_REQ=1 and owner DEF again.
  - The counter increments again.
- BUSY is treated as IDLE: no select ownership, no DEF_REQ.
- SLOT_EN=0 for all bits: every NONSEQ/SEQ goes to DEF.

Test Plan:
- Reset: assert HRESET 2 cycles with HTRANS=NONSEQ, HADDR=32'h1000_0000 → HREADY=1, HRESP=0, HRDATA=0, UNMAP_CNT=0, HSEL_S=16'h0002.
- Mapped read:
  - NONSEQ read to 32'h3000_0010; slave 3 drives HRDATA=32'hCAFE_0003, HREADYOUT=1 in the data phase.
  - Required: HRDATA=32'hCAFE_0003 and HREADY=1 on the cycle after the address edge.
  - With slave 3 stretching 2 wait states, HREADY=0 for 2 cycles and the owner holds while HADDR changes to 32'h0000_0000.
- Unmapped access, SLOT_EN=16'h00FF:
  - NONSEQ to 32'h9000_0000 → DEF_REQ=1 for one cycle.
  - The default slave's 0/1 then 1/1 HREADY/HRESP pattern is forwarded exactly.
  - HRDATA=0; UNMAP_CNT=1.
- Back-to-back: unmapped NONSEQ, then mapped SEQ to 32'h0000_0004 issued in the ERROR second cycle → the next data phase is owned by slave 0, with HRESP=0 and HRDATA from slave 0.
- IDLE/BUSY:
  - HTRANS=IDLE, then BUSY, to unmapped 32'hF000_0000 → DEF_REQ=0, owner NONE, HREADY=1, counter unchanged.
  - HSEL_S=0 for unmapped slots.
- Saturation, CNT_W=4: 17 unmapped NONSEQ accesses → UNMAP_CNT reaches 4'hF after 15 and stays 4'hF; HRESET then clears it to 0.

Source files
------------

// File: rtl/ahbl_addr_decode_resp_mux.sv
// AHB-Lite address decoder and response multiplexer for a single master.
// Decodes 256 MB slots, owns the data phase, and steers the owning slave's response back to the master.
module ahbl_addr_decode_resp_mux #(
  parameter logic [15:0] SLOT_EN = 16'h00FF,
  parameter int          CNT_W   = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  output logic [15:0]      HSEL_S,
  input  logic [15:0]      HREADYOUT_S,
  input  logic [15:0]      HRESP_S,
  input  logic [511:0]     HRDATA_S,
  output logic             DEF_REQ,
  input  logic             DEF_HREADYOUT,
  input  logic             DEF_HRESP,
  output logic             HREADY,
  output logic             HRESP,
  output logic [31:0]      HRDATA,
  output logic [CNT_W-1:0] UNMAP_CNT
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_SLV  = 2'd1,
    OWN_DEF  = 2'd2
  } own_kind_e;

  own_kind_e        own_kind_q, own_kind_d;
  logic [3:0]       own_idx_q, own_idx_d;
  logic [CNT_W-1:0] cnt_q;

  logic [3:0] slot;
  logic       mapped;
  logic       xfer;

  assign slot    = HADDR[31:28];
  assign mapped  = SLOT_EN[slot];
  assign xfer    = HTRANS[1];

  // Select is driven for any transfer type; only ownership looks at HTRANS.
  assign HSEL_S  = mapped ? (16'h0001 << slot) : 16'h0000;
  assign DEF_REQ = !mapped && xfer && HREADY;

  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = 32'h0000_0000;
    unique case (own_kind_q)
      OWN_SLV: begin
        HREADY = HREADYOUT_S[own_idx_q];
        HRESP  = HRESP_S[own_idx_q];
        HRDATA = HRDATA_S[{own_idx_q, 5'b00000} +: 32];
      end
      OWN_DEF: begin
        HREADY = DEF_HREADYOUT;
        HRESP  = DEF_HRESP;
      end
      default: ;
    endcase
  end

  always_comb begin
    own_kind_d = own_kind_q;
    own_idx_d  = own_idx_q;
    if (HREADY) begin
      if (!xfer) begin
        own_kind_d = OWN_NONE;
        own_idx_d  = 4'd0;
      end else if (mapped) begin
        own_kind_d = OWN_SLV;
        own_idx_d  = slot;
      end else begin
        own_kind_d = OWN_DEF;
        own_idx_d  = 4'd0;
      end
    end
  end

  // NOTE: reset is sampled on the clock edge, so it wins over a stalled data phase in the same cycle.
  always_ff @(posedge HCLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (HRESET) begin
      own_kind_q <= OWN_NONE;
      own_idx_q  <= 4'd0;
      cnt_q      <= '0;
    end else begin
      own_kind_q <= own_kind_d;
      own_idx_q  <= own_idx_d;
      if (DEF_REQ && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign UNMAP_CNT = cnt_q;

endmodule
